logic_gate_unit: RTL

Parametrised, pipelined bitwise logic unit: accepts two WIDTH-bit operands plus an opcode selecting one of eight gate functions (AND, OR, NOT_A, NOT_B, NAND, NOR, XOR, XNOR), and returns the registered result with status flags. It adds three things the single-bit gate block lacks: a valid/ready handshake on both sides, an internal accumulator usable as operand A, and a completed-operation counter. It sits between operand sources and downstream consumers in the logic-exercise datapath.

---
 rtl/logic_gate_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/logic_gate_unit.sv
// Two-stage pipelined bitwise gate unit with valid/ready on both sides, an accumulator
// usable as operand A, and a wrapping count of results taken downstream.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic             acc_wr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NOT_A = 3'd2;
  localparam logic [2:0] OP_NOT_B = 3'd3;
  localparam logic [2:0] OP_NAND  = 3'd4;
  localparam logic [2:0] OP_NOR   = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;

  logic             s1_valid;
  logic [2:0]       op_s1;
  logic             acc_sel_s1;
  logic             acc_wr_s1;
  logic [WIDTH-1:0] a_s1;
  logic [WIDTH-1:0] b_s1;

  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] gate_res;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Operand A resolved late so a beat right behind an accumulator write sees the new value.
  always_comb begin
    opa      = acc_sel_s1 ? acc : a_s1;
    gate_res = '0;
    case (op_s1)
      OP_AND:   gate_res = opa & b_s1;
      OP_OR:    gate_res = opa | b_s1;
      OP_NOT_A: gate_res = ~opa;
      OP_NOT_B: gate_res = ~b_s1;
      OP_NAND:  gate_res = ~(opa & b_s1);
      OP_NOR:   gate_res = ~(opa | b_s1);
      OP_XOR:   gate_res = opa ^ b_s1;
      default:  gate_res = ~(opa ^ b_s1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      op_s1      <= '0;
      acc_sel_s1 <= 1'b0;
      acc_wr_s1  <= 1'b0;
      a_s1       <= '0;
      b_s1       <= '0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      op_s1      <= op;
      acc_sel_s1 <= acc_sel;
      acc_wr_s1  <= acc_wr;
      a_s1       <= a;
      b_s1       <= b;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ones      <= 1'b0;
      parity    <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      result    <= gate_res;
      zero      <= (gate_res == '0);
      ones      <= (gate_res == '1);
      parity    <= ^gate_res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle write; the computation itself still saw the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (s1_adv && acc_wr_s1) begin
      acc <= gate_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
